// File: rtl/mic_screen_pkg.sv
// Shared constants and types for the animated microphone-test screen.
// Covers RGB565 colours, meter geometry and the enums used by the art and blink logic.
package mic_screen_pkg;

  localparam logic [15:0] C_BLACK  = 16'h0000;
  localparam logic [15:0] C_WHITE  = 16'hFFFF;
  localparam logic [15:0] C_GREEN  = 16'h07E0;
  localparam logic [15:0] C_YELLOW = 16'hFFE0;
  localparam logic [15:0] C_RED    = 16'hF800;
  localparam logic [15:0] C_DGREY  = 16'h4208;
  localparam logic [15:0] C_LIGHT  = 16'hC618;
  localparam logic [15:0] C_DARK   = 16'h7BEF;

  localparam logic [6:0] BAR_X0       = 7'd84;
  localparam logic [6:0] BAR_X1       = 7'd91;
  localparam logic [5:0] BAR_Y0       = 6'd58;
  localparam int         BAR_PITCH    = 4;
  localparam logic [6:0] SCREEN_X_MAX = 7'd95;

  typedef enum logic [1:0] {ART_NONE, ART_OUTLINE, ART_LIGHT, ART_DARK} art_class_e;
  typedef enum logic {BLINK_SHOW, BLINK_HIDE} blink_e;

endpackage

// File: rtl/mic_screen_art.sv
// Static artwork lookup: maps a pixel position to a microphone sprite class and a "MIC TEST" caption hit.
// The logic is purely combinational, so the top module registers the result in its first pipeline stage.
module mic_screen_art
  import mic_screen_pkg::*;
(
  input  logic [6:0]  x_i,
  input  logic [5:0]  y_i,
  output art_class_e  class_o,
  output logic        caption_o
);

  // 3x5 glyphs, row-major with the MSB at the top-left; caption text is "MIC TEST"
  function automatic logic [14:0] glyph_bits(input logic [2:0] idx);
    case (idx)
      3'd0:    glyph_bits = 15'b101_111_111_101_101;
      3'd1:    glyph_bits = 15'b111_010_010_010_111;
      3'd2:    glyph_bits = 15'b111_100_100_100_111;
      3'd3:    glyph_bits = 15'b000_000_000_000_000;
      3'd5:    glyph_bits = 15'b111_100_110_100_111;
      3'd6:    glyph_bits = 15'b111_100_111_001_111;
      default: glyph_bits = 15'b111_010_010_010_010;
    endcase
  endfunction

  logic [4:0]  cx;
  logic [2:0]  row;
  logic [14:0] gbits;
  int          bit_idx;

  always_comb begin
    cx        = 5'(x_i - 7'd8);
    row       = 3'(y_i - 6'd54);
    gbits     = glyph_bits(cx[4:2]);
    bit_idx   = 14 - (int'(row) * 3 + int'(cx[1:0]));
    caption_o = 1'b0;
    if (x_i >= 7'd8 && x_i <= 7'd39 && y_i >= 6'd54 && y_i <= 6'd58 && cx[1:0] != 2'd3)
      caption_o = gbits[4'(bit_idx)];
  end

  // Sprite: grilled capsule head, narrow stem, flat base
  always_comb begin
    class_o = ART_NONE;
    if (x_i >= 7'd40 && x_i <= 7'd55 && y_i >= 6'd8 && y_i <= 6'd31) begin
      if (x_i == 7'd40 || x_i == 7'd55 || y_i == 6'd8 || y_i == 6'd31)
        class_o = ART_OUTLINE;
      else if (y_i[1:0] == 2'b10)
        class_o = ART_DARK;
      else
        class_o = ART_LIGHT;
    end else if (x_i >= 7'd46 && x_i <= 7'd49 && y_i >= 6'd32 && y_i <= 6'd43) begin
      class_o = (x_i == 7'd46 || x_i == 7'd49) ? ART_OUTLINE : ART_DARK;
    end else if (x_i >= 7'd38 && x_i <= 7'd57 && y_i >= 6'd44 && y_i <= 6'd47) begin
      class_o = ART_OUTLINE;
    end
  end

endmodule

// File: rtl/mic_meter_screen.sv
// Microphone-test screen renderer: per-frame meter/peak/clip/blink state plus a 2-stage pixel pipeline.
// Stage 1 captures art class, caption and bar colour from the current state; stage 2 picks the final colour.
module mic_meter_screen
  import mic_screen_pkg::*;
#(
  parameter int LEVEL_W      = 12,
  parameter int N_BARS       = 8,
  parameter int BLINK_FRAMES = 30,
  parameter int DECAY_FRAMES = 4,
  parameter int CLIP_FRAMES  = 15
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               enable,
  input  logic               frame_begin,
  input  logic               pixel_valid,
  input  logic [6:0]         x,
  input  logic [5:0]         y,
  input  logic [LEVEL_W-1:0] mic_level,
  output logic [15:0]        oled_data,
  output logic               oled_valid
);

  localparam int LOG2   = $clog2(N_BARS);
  localparam int LIT_W  = LOG2 + 1;
  localparam int DEC_W  = $clog2(DECAY_FRAMES + 1);
  localparam int BLK_W  = $clog2(BLINK_FRAMES + 1);
  localparam int CLIP_W = $clog2(CLIP_FRAMES + 1);

  logic [LIT_W-1:0]  lit_q, peak_q, lit_d, peak_dec_d;
  logic [DEC_W-1:0]  decay_q;
  logic [CLIP_W-1:0] clip_q;
  logic [BLK_W-1:0]  blink_cnt_q;
  blink_e            blink_q;

  always_comb begin
    lit_d      = (mic_level == '0) ? '0 : {1'b0, mic_level[LEVEL_W-1 -: LOG2]} + LIT_W'(1);
    peak_dec_d = (peak_q - LIT_W'(1) > lit_d) ? peak_q - LIT_W'(1) : lit_d;
  end

  // Frame-rate state, including the SHOW/HIDE caption FSM; enable=0 overrides everything
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      lit_q <= '0; peak_q <= '0; decay_q <= '0; clip_q <= '0;
      blink_cnt_q <= '0; blink_q <= BLINK_SHOW;
    end else if (!enable) begin
      lit_q <= '0; peak_q <= '0; decay_q <= '0; clip_q <= '0;
      blink_cnt_q <= '0; blink_q <= BLINK_SHOW;
    end else if (frame_begin) begin
      lit_q <= lit_d;
      if (lit_d >= peak_q) begin
        peak_q  <= lit_d;
        decay_q <= '0;
      end else if (decay_q == DEC_W'(DECAY_FRAMES - 1)) begin
        peak_q  <= peak_dec_d;
        decay_q <= '0;
      end else begin
        decay_q <= decay_q + DEC_W'(1);
      end
      if (&mic_level)        clip_q <= CLIP_W'(CLIP_FRAMES);
      else if (clip_q != '0) clip_q <= clip_q - CLIP_W'(1);
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_q     <= (blink_q == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLK_W'(1);
      end
    end
  end

  art_class_e art_cls;
  logic       cap_hit;

  mic_screen_art u_art (
    .x_i       (x),
    .y_i       (y),
    .class_o   (art_cls),
    .caption_o (cap_hit)
  );

  logic [5:0]       bar_dist, bar_k, bar_row;
  logic [LIT_W-1:0] k_lit;
  logic             oob, bar_hit_d, cap_d;
  logic [15:0]      bar_col_d;

  always_comb begin
    oob       = x > SCREEN_X_MAX;
    bar_dist  = BAR_Y0 - y;
    bar_k     = bar_dist / 6'(BAR_PITCH);
    bar_row   = bar_dist % 6'(BAR_PITCH);
    k_lit     = LIT_W'(bar_k);
    bar_hit_d = (x >= BAR_X0) && (x <= BAR_X1) && (y <= BAR_Y0) &&
                (bar_row != 6'(BAR_PITCH - 1)) && (bar_k < 6'(N_BARS));
    cap_d     = cap_hit && (blink_q == BLINK_SHOW) && !oob;
    if (k_lit < lit_q) begin
      if (clip_q != '0)                     bar_col_d = C_RED;
      else if (k_lit < LIT_W'(N_BARS / 2))     bar_col_d = C_GREEN;
      else if (k_lit < LIT_W'(3 * N_BARS / 4)) bar_col_d = C_YELLOW;
      else                                  bar_col_d = C_RED;
    end else if (peak_q > lit_q && k_lit == peak_q - LIT_W'(1)) begin
      bar_col_d = C_WHITE;
    end else begin
      bar_col_d = C_DGREY;
    end
  end

  logic        v1_q, bar_hit1_q, cap1_q;
  logic [15:0] bar_col1_q, pix_col_d;
  art_class_e  cls1_q;

  always_comb begin
    if (bar_hit1_q)                pix_col_d = bar_col1_q;
    else if (cap1_q)               pix_col_d = C_WHITE;
    else if (cls1_q == ART_OUTLINE) pix_col_d = C_WHITE;
    else if (cls1_q == ART_LIGHT)   pix_col_d = C_LIGHT;
    else if (cls1_q == ART_DARK)    pix_col_d = C_DARK;
    else                           pix_col_d = C_BLACK;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      v1_q <= 1'b0; bar_hit1_q <= 1'b0; cap1_q <= 1'b0;
      bar_col1_q <= C_BLACK; cls1_q <= ART_NONE;
      oled_valid <= 1'b0; oled_data <= C_BLACK;
    end else begin
      v1_q       <= pixel_valid;
      bar_hit1_q <= bar_hit_d && !oob;
      cap1_q     <= cap_d;
      bar_col1_q <= bar_col_d;
      cls1_q     <= oob ? ART_NONE : art_cls;
      oled_valid <= v1_q;
      if (v1_q) oled_data <= pix_col_d;
    end
  end

endmodule

// File: tb/tb_mic_meter_screen.sv
// Directed bench for mic_meter_screen: a vector table of frame+pixel probes plus hand sequences
// for reset, peak decay, clip timing, caption blink, same-cycle frame update and streaming.
module tb_mic_meter_screen;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        enable = 1'b1;
  logic        frame_begin = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [6:0]  x = '0;
  logic [5:0]  y = '0;
  logic [11:0] mic_level = '0;
  logic [15:0] oled_data;
  logic        oled_valid;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] K_BLACK = 16'h0000, K_WHITE = 16'hFFFF, K_GREEN = 16'h07E0,
                          K_YELLOW = 16'hFFE0, K_RED = 16'hF800, K_DGREY = 16'h4208,
                          K_LIGHT = 16'hC618, K_DARK = 16'h7BEF;

  mic_meter_screen dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .enable      (enable),
    .frame_begin (frame_begin),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .mic_level   (mic_level),
    .oled_data   (oled_data),
    .oled_valid  (oled_valid)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [11:0] level;
    logic [6:0]  px;
    logic [5:0]  py;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string name, input logic v, input logic [15:0] d,
                       input logic ev, input logic [15:0] ed);
    n_tests++;
    if ({v, d} !== {ev, ed}) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b data=%04h, want valid=%0b data=%04h", name, v, d, ev, ed);
    end else begin
      $display("[TB] ok %s valid=%0b data=%04h", name, v, d);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; enable = 1'b1; frame_begin = 1'b0; pixel_valid = 1'b0;
    x = '0; y = '0; mic_level = '0;
    tick(); tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic frame(input logic [11:0] level);
    frame_begin = 1'b1; mic_level = level;
    tick();
    frame_begin = 1'b0;
  endtask

  task automatic probe(input string name, input logic [6:0] px, input logic [5:0] py,
                       input logic [15:0] exp);
    pixel_valid = 1'b1; x = px; y = py;
    tick();
    pixel_valid = 1'b0;
    tick();
    check(name, oled_valid, oled_data, 1'b1, exp);
  endtask

  initial begin
    vecs[0]  = '{12'h000, 7'd86, 6'd58, K_DGREY};
    vecs[1]  = '{12'h001, 7'd86, 6'd58, K_GREEN};
    vecs[2]  = '{12'h001, 7'd86, 6'd54, K_DGREY};
    vecs[3]  = '{12'h200, 7'd86, 6'd54, K_GREEN};
    vecs[4]  = '{12'h200, 7'd86, 6'd50, K_DGREY};
    vecs[5]  = '{12'h800, 7'd86, 6'd42, K_YELLOW};
    vecs[6]  = '{12'h800, 7'd86, 6'd38, K_DGREY};
    vecs[7]  = '{12'h800, 7'd86, 6'd39, K_BLACK};
    vecs[8]  = '{12'hC00, 7'd86, 6'd34, K_RED};
    vecs[9]  = '{12'h200, 7'd86, 6'd34, K_WHITE};
    vecs[10] = '{12'h200, 7'd100, 6'd10, K_BLACK};
    vecs[11] = '{12'h200, 7'd8, 6'd54, K_WHITE};
    vecs[12] = '{12'h200, 7'd41, 6'd9, K_LIGHT};
    vecs[13] = '{12'h200, 7'd41, 6'd10, K_DARK};
    vecs[14] = '{12'h200, 7'd40, 6'd20, K_WHITE};
    vecs[15] = '{12'h200, 7'd47, 6'd35, K_DARK};
    vecs[16] = '{12'h200, 7'd50, 6'd45, K_WHITE};
    vecs[17] = '{12'h200, 7'd0, 6'd0, K_BLACK};

    // Reset state, first pixel with no frame yet, and output hold when pixel_valid drops
    RESET_N = 1'b0;
    #3;
    check("reset_out", oled_valid, oled_data, 1'b0, K_BLACK);
    do_reset();
    probe("no_frame_bar0", 7'd86, 6'd58, K_DGREY);
    tick();
    check("hold_after_invalid", oled_valid, oled_data, 1'b0, K_DGREY);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      frame(vecs[i].level);
      probe($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].exp);
    end

    // Peak hold, decay and clip timing
    do_reset();
    frame(12'hFFF);
    probe("clip_bar7_red", 7'd86, 6'd30, K_RED);
    frame(12'h000);
    probe("peak_bar7_white", 7'd86, 6'd30, K_WHITE);
    frame(12'h000); frame(12'h000);
    probe("peak_held_3fr", 7'd86, 6'd30, K_WHITE);
    frame(12'h000);
    probe("peak_decayed_bar7", 7'd86, 6'd30, K_DGREY);
    probe("peak_decayed_bar6", 7'd86, 6'd34, K_WHITE);
    for (int i = 0; i < 10; i++) frame(12'h800);
    probe("clip_last_frame", 7'd86, 6'd58, K_RED);
    frame(12'h800);
    probe("clip_expired", 7'd86, 6'd58, K_GREEN);

    // Asynchronous reset mid-cycle
    #3;
    RESET_N = 1'b0;
    #1;
    check("async_reset", oled_valid, oled_data, 1'b0, K_BLACK);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    probe("after_reset_lit0", 7'd86, 6'd58, K_DGREY);

    // Caption blink
    do_reset();
    probe("cap_show0", 7'd8, 6'd54, K_WHITE);
    for (int i = 0; i < 29; i++) frame(12'h000);
    probe("cap_show29", 7'd8, 6'd54, K_WHITE);
    frame(12'h000);
    probe("cap_hide30", 7'd8, 6'd54, K_BLACK);
    for (int i = 0; i < 29; i++) frame(12'h000);
    probe("cap_hide59", 7'd8, 6'd54, K_BLACK);
    frame(12'h000);
    probe("cap_show60", 7'd8, 6'd54, K_WHITE);
    for (int i = 0; i < 30; i++) frame(12'h000);
    probe("cap_hide90", 7'd8, 6'd54, K_BLACK);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    probe("cap_enable_off", 7'd8, 6'd54, K_WHITE);

    // Frame update in the same cycle as a pixel: that pixel sees the old state
    do_reset();
    frame_begin = 1'b1; mic_level = 12'hFFF;
    pixel_valid = 1'b1; x = 7'd86; y = 6'd54;
    tick();
    frame_begin = 1'b0;
    tick();
    pixel_valid = 1'b0;
    check("same_cycle_old", oled_valid, oled_data, 1'b1, K_DGREY);
    tick();
    check("next_pixel_new", oled_valid, oled_data, 1'b1, K_RED);

    // Full-frame streaming: every valid pixel emerges exactly two cycles later
    do_reset();
    begin
      int pulses = 0;
      int late = 0;
      for (int i = 0; i < 6146; i++) begin
        pixel_valid = (i < 6144);
        x = 7'((i % 96));
        y = 6'((i / 96) % 64);
        tick();
        if (oled_valid) pulses++;
        if (oled_valid !== (i >= 1 && i <= 6144)) late++;
      end
      pixel_valid = 1'b0;
      check_int("stream_pulses", pulses, 6144);
      check_int("stream_timing_errs", late, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
